// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port-B arbiter: FSM encoding and requester indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Ownership state that corresponds to a locked grant for requester k.
  function automatic arb_state_e own_state(input logic k);
    return k ? OWN1 : OWN0;
  endfunction

  // Eligibility mask: who may be granted in a given arbiter state.
  function automatic logic [1:0] own_mask(input arb_state_e s);
    case (s)
      IDLE:    return 2'b11;
      OWN0:    return 2'b01;
      OWN1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; ptr names the requester that wins a tie.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] elig;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    elig  = req & mask;
    grant = 2'b00;
    if (elig == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares memory port B between the CPU data path and the copy/video engine, with
// per-access round robin, optional locked bursts and a tagged 1-cycle read return.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA     = 18,
  parameter int ADDR     = 14,
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            reset_n,

  input  logic            r0_req,
  input  logic            r0_wr,
  input  logic            r0_lock,
  input  logic [ADDR-1:0] r0_addr,
  input  logic [DATA-1:0] r0_din,
  output logic            r0_gnt,
  output logic            r0_rvalid,
  output logic [DATA-1:0] r0_dout,

  input  logic            r1_req,
  input  logic            r1_wr,
  input  logic            r1_lock,
  input  logic [ADDR-1:0] r1_addr,
  input  logic [DATA-1:0] r1_din,
  output logic            r1_gnt,
  output logic            r1_rvalid,
  output logic [DATA-1:0] r1_dout,

  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  arb_state_e       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_tag_q, rd_tag_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [DATA-1:0]  din_q, din_d;
  logic [DATA-1:0]  dout0_q, dout0_d;
  logic [DATA-1:0]  dout1_q, dout1_d;

  logic [1:0]       pick;
  logic [1:0]       grant;
  logic             any_gnt;
  logic             gnt_idx;
  logic             sel_wr;
  logic             sel_lock;
  logic [ADDR-1:0]  sel_addr;
  logic [DATA-1:0]  sel_din;

  rr_pick2 u_pick (
    .req   ({r1_req, r0_req}),
    .ptr   (rr_ptr_q),
    .mask  (own_mask(state_q)),
    .grant (pick)
  );

  // Grants are masked by reset so mem_wr drops the moment reset asserts.
  assign grant   = pick & {2{reset_n}};
  assign any_gnt = |grant;
  assign gnt_idx = grant[REQ_DMA] ? REQ_DMA : REQ_CPU;
  assign r0_gnt  = grant[REQ_CPU];
  assign r1_gnt  = grant[REQ_DMA];

  always_comb begin
    sel_wr   = (gnt_idx == REQ_DMA) ? r1_wr   : r0_wr;
    sel_lock = (gnt_idx == REQ_DMA) ? r1_lock : r0_lock;
    sel_addr = (gnt_idx == REQ_DMA) ? r1_addr : r0_addr;
    sel_din  = (gnt_idx == REQ_DMA) ? r1_din  : r0_din;

    mem_wr   = any_gnt & sel_wr;
    mem_addr = any_gnt ? sel_addr : addr_q;
    mem_din  = any_gnt ? sel_din  : din_q;
    addr_d   = mem_addr;
    din_d    = mem_din;
  end

  // Ownership FSM and burst length limiter.
  always_comb begin
    logic own_idx;
    logic own_req;
    logic own_lock;
    logic exit_own;

    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    own_idx    = (state_q == OWN1);
    own_req    = own_idx ? r1_req  : r0_req;
    own_lock   = own_idx ? r1_lock : r0_lock;
    exit_own   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          rr_ptr_d = ~gnt_idx;
          if (sel_lock) begin
            state_d    = own_state(gnt_idx);
            lock_cnt_d = CNT_W'(1);
          end
        end
      end
      OWN0, OWN1: begin
        if (any_gnt) begin
          if (!own_lock || lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
            exit_own = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end else if (!own_req && !own_lock) begin
          exit_own = 1'b1;
        end
        if (exit_own) begin
          state_d    = IDLE;
          rr_ptr_d   = ~own_idx;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // The owner tag follows each read by one cycle so alternating returns never cross.
  always_comb begin
    rd_pend_d = any_gnt & ~sel_wr;
    rd_tag_d  = any_gnt ? gnt_idx : rd_tag_q;

    r0_rvalid = rd_pend_q & (rd_tag_q == REQ_CPU);
    r1_rvalid = rd_pend_q & (rd_tag_q == REQ_DMA);
    r0_dout   = r0_rvalid ? mem_dout : dout0_q;
    r1_dout   = r1_rvalid ? mem_dout : dout1_q;
    dout0_d   = r0_dout;
    dout1_d   = r1_dout;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= REQ_CPU;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= REQ_CPU;
      addr_q     <= '0;
      din_q      <= '0;
      dout0_q    <= '0;
      dout1_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      dout0_q    <= dout0_d;
      dout1_q    <= dout1_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a behavioural ownership/priority model.
module tb_mem_port_arbiter;

  localparam int DATA     = 18;
  localparam int ADDR     = 14;
  localparam int LOCK_MAX = 16;
  localparam int DEPTH    = 1 << ADDR;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req, wr, lock;
  logic [ADDR-1:0] addr [2];
  logic [DATA-1:0] din  [2];
  logic            gnt    [2];
  logic            rvalid [2];
  logic [DATA-1:0] dout   [2];
  logic            mem_wr;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_din;
  logic [DATA-1:0] mem_dout = '0;

  logic [DATA-1:0] tb_mem  [DEPTH];
  logic [DATA-1:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the port, how long the burst is, who wins a tie.
  int              m_owner;
  int              m_burst;
  int              m_prio;
  int              m_rd_who;
  logic [DATA-1:0] m_rd_data;
  logic [DATA-1:0] m_last_dout [2];
  logic [ADDR-1:0] m_last_addr;
  logic [DATA-1:0] m_last_din;

  int              obs_g;
  logic            obs_rv   [2];
  logic [DATA-1:0] obs_dout [2];
  logic            obs_mem_wr;
  int              gseq [32];

  mem_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .r0_req    (req[0]),
    .r0_wr     (wr[0]),
    .r0_lock   (lock[0]),
    .r0_addr   (addr[0]),
    .r0_din    (din[0]),
    .r0_gnt    (gnt[0]),
    .r0_rvalid (rvalid[0]),
    .r0_dout   (dout[0]),
    .r1_req    (req[1]),
    .r1_wr     (wr[1]),
    .r1_lock   (lock[1]),
    .r1_addr   (addr[1]),
    .r1_din    (din[1]),
    .r1_gnt    (gnt[1]),
    .r1_rvalid (rvalid[1]),
    .r1_dout   (dout[1]),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  // Memory port B: synchronous write, registered 1-cycle read.
  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr] <= mem_din;
    mem_dout <= tb_mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner     = -1;
    m_burst     = 0;
    m_prio      = 0;
    m_rd_who    = -1;
    m_rd_data   = '0;
    m_last_dout = '{default: '0};
    m_last_addr = '0;
    m_last_din  = '0;
  endtask

  // Hold reset across one rising edge; checks run while reset is asserted.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    check("rst_gnt0",   gnt[0],    0);
    check("rst_gnt1",   gnt[1],    0);
    check("rst_rv0",    rvalid[0], 0);
    check("rst_rv1",    rvalid[1], 0);
    check("rst_mem_wr", mem_wr,    0);
    check("rst_addr",   mem_addr,  0);
    check("rst_din",    mem_din,   0);
    check("rst_dout0",  dout[0],   0);
    check("rst_dout1",  dout[1],   0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    int eg;
    @(negedge clk);
    eg = -1;
    if (m_owner >= 0) begin
      if (req[m_owner]) eg = m_owner;
    end else if (req == 2'b11) eg = m_prio;
    else if (req[0]) eg = 0;
    else if (req[1]) eg = 1;

    check("gnt0",   gnt[0], eg == 0);
    check("gnt1",   gnt[1], eg == 1);
    check("mem_wr", mem_wr, (eg >= 0) ? wr[eg] : 1'b0);
    check("mem_addr", mem_addr, (eg >= 0) ? addr[eg] : m_last_addr);
    check("mem_din",  mem_din,  (eg >= 0) ? din[eg]  : m_last_din);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rvalid%0d", k), rvalid[k], m_rd_who == k);
      check($sformatf("dout%0d", k), dout[k], (m_rd_who == k) ? m_rd_data : m_last_dout[k]);
      obs_rv[k]   = rvalid[k];
      obs_dout[k] = dout[k];
    end
    obs_g      = gnt[0] ? 0 : (gnt[1] ? 1 : -1);
    obs_mem_wr = mem_wr;

    @(posedge clk);
    if (m_rd_who >= 0) m_last_dout[m_rd_who] = m_rd_data;
    m_rd_who = -1;
    if (eg >= 0) begin
      if (wr[eg]) ref_mem[addr[eg]] = din[eg];
      else begin
        m_rd_who  = eg;
        m_rd_data = ref_mem[addr[eg]];
      end
      m_last_addr = addr[eg];
      m_last_din  = din[eg];
      m_prio      = 1 - eg;
      if (m_owner < 0) begin
        if (lock[eg]) begin
          m_owner = eg;
          m_burst = 1;
        end
      end else begin
        m_burst++;
        if (!lock[eg] || m_burst == LOCK_MAX) m_owner = -1;
      end
    end else if (m_owner >= 0 && !req[m_owner] && !lock[m_owner]) begin
      m_prio  = 1 - m_owner;
      m_owner = -1;
    end
    #1;
  endtask

  initial begin
    int r0_reads;
    int lead;
    logic [DATA-1:0] tmp;

    for (int i = 0; i < DEPTH; i++) begin
      tmp        = DATA'($urandom);
      tb_mem[i]  = tmp;
      ref_mem[i] = tmp;
    end
    tb_mem[16'h0010]  = 18'h2A5C3;
    ref_mem[16'h0010] = 18'h2A5C3;

    req  = 2'b11;
    wr   = 2'b11;
    lock = 2'b00;
    addr = '{default: '0};
    din  = '{default: '0};
    obs_g = -1;
    do_reset();
    req = 2'b00;
    wr  = 2'b00;

    // Single read after reset.
    req = 2'b01; addr[0] = 14'h0010;
    step();
    check("t1_gnt", obs_g, 0);
    req = 2'b00;
    step();
    check("t1_rv0",   obs_rv[0],   1);
    check("t1_dout0", obs_dout[0], 18'h2A5C3);
    check("t1_rv1",   obs_rv[1],   0);

    // Both requesting every cycle: strict alternation.
    do_reset();
    addr[0] = 14'h0100; addr[1] = 14'h0200; req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      gseq[i] = obs_g;
      if (obs_g >= 0) addr[obs_g] = addr[obs_g] + 14'd1;
    end
    req = 2'b00;
    step();
    for (int i = 0; i < 6; i++) check($sformatf("t2_gnt%0d", i), gseq[i], i % 2);

    // Top-address write then read back.
    req = 2'b10; wr = 2'b10; addr[1] = 14'h3FFF; din[1] = 18'h3FFFF;
    step();
    check("t3_wgnt", obs_g, 1);
    check("t3_wr",   obs_mem_wr, 1);
    req = 2'b01; wr = 2'b00; addr[0] = 14'h3FFF;
    step();
    check("t3_rgnt", obs_g, 0);
    check("t3_rd_wr", obs_mem_wr, 0);
    req = 2'b00;
    step();
    check("t3_rv0",   obs_rv[0],   1);
    check("t3_dout0", obs_dout[0], 18'h3FFFF);

    // Locked burst of 20 reads against a waiting r1: forced release after LOCK_MAX.
    do_reset();
    req = 2'b11; lock = 2'b01; addr[0] = 14'h0400; addr[1] = 14'h0500;
    r0_reads = 0;
    for (int i = 0; i < 40 && r0_reads < 20; i++) begin
      if (r0_reads == 19) lock[0] = 1'b0;
      step();
      if (i < 32) gseq[i] = obs_g;
      if (obs_g == 0) begin
        r0_reads++;
        addr[0] = addr[0] + 14'd1;
      end
      if (obs_g == 1) req[1] = 1'b0;
    end
    req = 2'b00; lock = 2'b00;
    step();
    check("t4_reads", r0_reads, 20);
    lead = 0;
    while (lead < 18 && gseq[lead] == 0) lead++;
    check("t4_burst", lead, LOCK_MAX);
    check("t4_next1", gseq[16], 1);
    check("t4_next0", gseq[17], 0);

    // Idle owner keeps r1 locked out until it drops lock.
    do_reset();
    req = 2'b01; lock = 2'b01; addr[0] = 14'h0020;
    step();
    check("t5_lockgnt", obs_g, 0);
    req = 2'b10; addr[1] = 14'h0030;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5_block%0d", i), obs_g, -1);
    end
    lock = 2'b00;
    step();
    check("t5_release", obs_g, -1);
    step();
    check("t5_r1gnt", obs_g, 1);
    req = 2'b00;
    step();

    // Reset right after an r1 read grant drops the pending return.
    req = 2'b10; addr[1] = 14'h0040;
    step();
    check("t6_gnt", obs_g, 1);
    req = 2'b11; wr = 2'b11;
    do_reset();
    wr = 2'b00; addr[0] = 14'h0050; addr[1] = 14'h0060;
    step();
    check("t6_rv1", obs_rv[1], 0);
    check("t6_prio", obs_g, 0);
    req = 2'b00;
    step();

    // Random traffic honouring the requester contract.
    do_reset();
    obs_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!req[k] || obs_g == k) begin
          req[k]  = ($urandom % 3) != 0;
          wr[k]   = $urandom % 2;
          addr[k] = ADDR'($urandom_range(0, 31));
          din[k]  = DATA'($urandom);
        end else if ($urandom % 16 == 0) begin
          req[k] = 1'b0;
        end
        lock[k] = ($urandom % 4) == 0;
      end
      step();
    end
    req = 2'b00; lock = 2'b00;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of the dual-port `memory` block (port B; port A stays with instruction fetch) between two requesters: requester 0 = CPU data path, requester 1 = block-copy/video-load engine.
- Performs round-robin arbitration per access and supports an optional locked burst.
- Provides a read-return path timed to the memory's 1-cycle registered read.
- Sits between the requesters and the memory's `b_*` pins.

Parameters:
- DATA, 18, memory word width (matches memory DATA).
- ADDR, 14, memory address width (matches memory ADDR).
- LOCK_MAX, 16, maximum consecutive granted cycles under lock before ownership is forcibly released.

Ports:
- clk  in  1  single clock; also drives memory b_clk.
- reset_n  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 access request; held until granted.
- r0_wr  in  1  1 = write, 0 = read.
- r0_lock  in  1  keep ownership after this access (burst).
- r0_addr  in  ADDR  access address.
- r0_din  in  DATA  write data.
- r0_gnt  out  1  access accepted this cycle.
- r0_rvalid  out  1  read data valid.
- r0_dout  out  DATA  read data.
- r1_req, r1_wr, r1_lock, r1_addr, r1_din, r1_gnt, r1_rvalid, r1_dout: same as requester 0, for requester 1.
- mem_wr  out  1  to memory b_wr.
- mem_addr  out  ADDR  to memory b_addr.
- mem_din  out  DATA  to memory b_din.
- mem_dout  in  DATA  from memory b_dout.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0 (requester 0 has priority), lock_cnt=0, rvalid regs=0.
- Reset values of outputs: r0_gnt=r1_gnt=0, r*_rvalid=0, mem_wr=0, mem_addr=0, mem_din=0, r*_dout=0.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - Grant is combinational from req and rr_ptr. Only one req set -> that requester wins. Both set -> requester rr_ptr wins.
  - On a grant to k: rr_ptr <= ~k (the granted requester becomes lowest priority).
  - If rk_lock=1 with the grant, go to OWNk with lock_cnt=1.
- OWNk:
  - Only requester k can be granted, whenever rk_req=1. The other requester waits even if k is idle.
  - Exit to IDLE when any of these holds:
    - a granted access has rk_lock=0;
    - rk_req=0 and rk_lock=0;
    - lock_cnt reaches LOCK_MAX-1 on a grant (that access completes, then forced exit).
  - On exit, rr_ptr = other requester.
- Memory drive:
  - In a cycle where rk_gnt=1: mem_addr=rk_addr, mem_din=rk_din, mem_wr=rk_wr.
  - No grant: mem_wr=0; mem_addr/mem_din hold their last value (registered hold).
  - The port is fully combinational from requester to memory; 0 added latency.
- At most one gnt per cycle; r0_gnt & r1_gnt is never 1.
- Read return:
  - Granted read in cycle N -> rk_rvalid=1 in cycle N+1, rk_dout=mem_dout (memory's registered output).
  - Granted write produces no rvalid.
  - r*_dout holds its last value when rvalid=0.
- Back-to-back reads from alternating requesters:
  - One access per cycle.
  - rvalid routes via a 1-cycle registered owner tag, so overlapping returns are never misrouted.
- Requester contract:
  - Requester keeps req/addr/din stable until gnt.
  - Dropping req before gnt is legal. It cancels the request with no side effect.
- Reset mid-operation:
  - A pending rvalid is dropped.
  - Lock ownership is lost.
  - The memory contents are not touched; mem_wr goes low asynchronously.
- Address/data pass through unmodified; no arithmetic except lock_cnt, which is $clog2(LOCK_MAX)+1 bits and saturates only via the forced exit.

Decomposition:
- Shared package `mem_arb_pkg`:
  - state encoding constants: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2;
  - requester index constants: REQ_CPU=1'b0, REQ_DMA=1'b1.
- One natural sub-module: `rr_pick2`, the combinational 2-way round-robin picker (inputs req[1:0], ptr, owner-mask; output grant[1:0]). Reused by a future video port arbiter.
- The rest stays in the top: FSM, lock counter, rvalid tag, memory mux.

Test Plan:
- Reset then r0 read addr 0x0010 (memory preloaded 0x2A5C3) -> r0_gnt in cycle 0; r0_rvalid=1 and r0_dout=0x2A5C3 in cycle 1; r1_rvalid stays 0.
- Both req every cycle, no lock, 6 reads -> grants alternate 0,1,0,1,0,1; each rvalid/dout arrives at the matching requester one cycle later with no misroute.
- r1 write 0x3FFFF to 0x3FFF (top address), then r0 read of 0x3FFF -> mem_wr=1 only in the write cycle; r0_dout=0x3FFFF the next cycle after its grant.
- r0 lock burst of 20 reads with r1_req held high -> 16 consecutive r0 grants; forced exit; next grant goes to r1; r0 is re-granted after r1.
- r0 issues a locked grant then idles with req=0 and lock=1 -> r1 receives no gnt while in OWN0; once r0 lock=0, r1 is granted in the following cycle.
- Assert reset_n=0 for 1 cycle right after an r1 read grant -> r1_rvalid never pulses; state IDLE; rr_ptr=0 (r0 wins the next simultaneous request).
